// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, ALU operations, datapath mux selects and the
// control-FSM state encoding used by lc3b_control_full.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef enum logic [1:0] {
        pcmux_pc_plus2 = 2'd0,
        pcmux_br_adder = 2'd1,
        pcmux_sr1      = 2'd2,
        pcmux_mdr      = 2'd3
    } lc3b_pcmux_sel;

    typedef enum logic [1:0] {
        marmux_alu      = 2'd0,
        marmux_pc       = 2'd1,
        marmux_mdr      = 2'd2,
        marmux_trapvect = 2'd3
    } lc3b_marmux_sel;

    typedef enum logic [2:0] {
        rfmux_alu      = 3'd0,
        rfmux_mdr      = 3'd1,
        rfmux_mdr_byte = 3'd2,
        rfmux_pc       = 3'd3,
        rfmux_br_adder = 3'd4
    } lc3b_regfilemux_sel;

    typedef enum logic [1:0] {
        alumux_sr2      = 2'd0,
        alumux_off6_shl = 2'd1,
        alumux_off6     = 2'd2,
        alumux_imm4     = 2'd3
    } lc3b_alumux_sel;

    typedef enum logic [4:0] {
        s_fetch1, s_fetch2, s_fetch3, s_decode,
        s_add, s_and, s_not, s_shf, s_lea,
        s_br, s_br_taken, s_jmp, s_jsr,
        s_calc_addr, s_calc_addr_b, s_ind1, s_ind2,
        s_ldr1, s_ldr2, s_ldb1, s_ldb2,
        s_str1, s_str2, s_stb1, s_stb2,
        s_trap1, s_trap2, s_trap3
    } lc3b_ctrl_state;

    // States that hold a memory request open until mem_resp.
    function automatic logic is_mem_wait(lc3b_ctrl_state s);
        return s inside {s_fetch2, s_ind1, s_ldr1, s_ldb1, s_str2, s_stb2, s_trap2};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_resp; flags expiry when the wait reaches
// MEM_TIMEOUT with no response. MEM_TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TIMEOUT_W   = $clog2(MEM_TIMEOUT + 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic resp,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (!resp) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // A response in the limit cycle wins over the abort.
    always_comb begin
        expired = (MEM_TIMEOUT != 0) && !clear && !resp && (count == LIMIT);
    end

endmodule

// File: rtl/lc3b_control_full.sv
// Multicycle Moore control FSM for the LC-3b datapath covering the full
// non-privileged ISA, with an optional memory-response watchdog.
module lc3b_control_full
    import lc3b_types::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TIMEOUT_W   = $clog2(MEM_TIMEOUT + 2)
) (
    input  logic        clk,
    input  logic        reset,
    input  lc3b_opcode  opcode,
    input  logic        branch_enable,
    input  logic        jsr_mode,
    input  logic [1:0]  shf_mode,
    input  logic        mar_lsb,
    input  logic        mem_resp,
    output logic        load_pc,
    output logic        load_ir,
    output logic        load_regfile,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_cc,
    output logic [1:0]  pcmux_sel,
    output logic        adjmux_sel,
    output logic [1:0]  marmux_sel,
    output logic [2:0]  regfilemux_sel,
    output logic        destmux_sel,
    output logic [1:0]  alumux_sel,
    output logic        storemux_sel,
    output logic        mdrmux_sel,
    output lc3b_aluop   aluop,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic        mem_timeout
);

    lc3b_ctrl_state state, state_next;
    logic           wait_clear;
    logic           wait_expired;

    assign wait_clear = !is_mem_wait(state);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMEOUT_W  (TIMEOUT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .resp   (mem_resp),
        .expired(wait_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_fetch1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = pcmux_pc_plus2;
        adjmux_sel      = 1'b0;
        marmux_sel      = marmux_alu;
        regfilemux_sel  = rfmux_alu;
        destmux_sel     = 1'b0;
        alumux_sel      = alumux_sr2;
        storemux_sel    = 1'b0;
        mdrmux_sel      = 1'b0;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        mem_timeout     = 1'b0;

        unique case (state)
            s_fetch1: begin
                load_mar   = 1'b1;
                marmux_sel = marmux_pc;
                load_pc    = 1'b1;
                state_next = s_fetch2;
            end
            s_fetch2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (mem_resp) state_next = s_fetch3;
            end
            s_fetch3: begin
                load_ir    = 1'b1;
                state_next = s_decode;
            end
            s_decode: begin
                case (opcode)
                    op_add:                        state_next = s_add;
                    op_and:                        state_next = s_and;
                    op_not:                        state_next = s_not;
                    op_shf:                        state_next = s_shf;
                    op_lea:                        state_next = s_lea;
                    op_br:                         state_next = s_br;
                    op_jmp:                        state_next = s_jmp;
                    op_jsr:                        state_next = s_jsr;
                    op_ldr, op_str, op_ldi, op_sti: state_next = s_calc_addr;
                    op_ldb, op_stb:                state_next = s_calc_addr_b;
                    op_trap:                       state_next = s_trap1;
                    default:                       state_next = s_fetch1;
                endcase
            end
            s_add, s_and, s_not: begin
                aluop        = (state == s_add) ? alu_add :
                               (state == s_and) ? alu_and : alu_not;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = s_fetch1;
            end
            s_shf: begin
                alumux_sel = alumux_imm4;
                case (shf_mode)
                    2'b00:   aluop = alu_sll;
                    2'b11:   aluop = alu_sra;
                    default: aluop = alu_srl;
                endcase
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                state_next   = s_fetch1;
            end
            s_lea: begin
                regfilemux_sel = rfmux_br_adder;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                state_next     = s_fetch1;
            end
            s_br: begin
                state_next = branch_enable ? s_br_taken : s_fetch1;
            end
            s_br_taken: begin
                pcmux_sel  = pcmux_br_adder;
                load_pc    = 1'b1;
                state_next = s_fetch1;
            end
            s_jmp: begin
                pcmux_sel  = pcmux_sr1;
                load_pc    = 1'b1;
                state_next = s_fetch1;
            end
            s_jsr: begin
                // R7 and PC update on the same edge; SR1 still reads the old R7.
                load_regfile   = 1'b1;
                destmux_sel    = 1'b1;
                regfilemux_sel = rfmux_pc;
                load_pc        = 1'b1;
                pcmux_sel      = jsr_mode ? pcmux_br_adder : pcmux_sr1;
                adjmux_sel     = jsr_mode;
                state_next     = s_fetch1;
            end
            s_calc_addr: begin
                alumux_sel = alumux_off6_shl;
                load_mar   = 1'b1;
                case (opcode)
                    op_ldr:         state_next = s_ldr1;
                    op_str:         state_next = s_str1;
                    op_ldi, op_sti: state_next = s_ind1;
                    default:        state_next = s_fetch1;
                endcase
            end
            s_calc_addr_b: begin
                alumux_sel = alumux_off6;
                load_mar   = 1'b1;
                state_next = (opcode == op_stb) ? s_stb1 : s_ldb1;
            end
            s_ind1, s_ldr1, s_ldb1, s_trap2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                if (mem_resp) begin
                    case (state)
                        s_ind1:  state_next = s_ind2;
                        s_ldr1:  state_next = s_ldr2;
                        s_ldb1:  state_next = s_ldb2;
                        default: state_next = s_trap3;
                    endcase
                end
            end
            s_ind2: begin
                marmux_sel = marmux_mdr;
                load_mar   = 1'b1;
                state_next = (opcode == op_sti) ? s_str1 : s_ldr1;
            end
            s_ldr2, s_ldb2: begin
                regfilemux_sel = (state == s_ldr2) ? rfmux_mdr : rfmux_mdr_byte;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                state_next     = s_fetch1;
            end
            s_str1, s_stb1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
                state_next   = (state == s_str1) ? s_str2 : s_stb2;
            end
            s_str2, s_stb2: begin
                mem_write = 1'b1;
                if (state == s_stb2) mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
                if (mem_resp) state_next = s_fetch1;
            end
            s_trap1: begin
                load_regfile   = 1'b1;
                destmux_sel    = 1'b1;
                regfilemux_sel = rfmux_pc;
                load_mar       = 1'b1;
                marmux_sel     = marmux_trapvect;
                state_next     = s_trap2;
            end
            s_trap3: begin
                pcmux_sel  = pcmux_mdr;
                load_pc    = 1'b1;
                state_next = s_fetch1;
            end
            default: state_next = s_fetch1;
        endcase

        if (wait_expired) begin
            state_next  = s_fetch1;
            mem_timeout = 1'b1;
        end
    end

endmodule

// File: tb/tb_lc3b_control_full.sv
// Directed bench for lc3b_control_full: a behavioural LC-3b datapath and
// memory driven by the control outputs, checked with immediate assertions.
module tb_lc3b_control_full;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, branch_enable, jsr_mode, mar_lsb, mem_resp;
    lc3b_opcode  opcode;
    logic [1:0]  shf_mode;
    logic        load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic [1:0]  pcmux_sel, marmux_sel, alumux_sel, mem_byte_enable;
    logic        adjmux_sel, destmux_sel, storemux_sel, mdrmux_sel;
    logic [2:0]  regfilemux_sel;
    lc3b_aluop   aluop;
    logic        mem_read, mem_write, mem_timeout;

    lc3b_control_full #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_enable(branch_enable),
        .jsr_mode(jsr_mode), .shf_mode(shf_mode), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
        .pcmux_sel(pcmux_sel), .adjmux_sel(adjmux_sel), .marmux_sel(marmux_sel),
        .regfilemux_sel(regfilemux_sel), .destmux_sel(destmux_sel),
        .alumux_sel(alumux_sel), .storemux_sel(storemux_sel), .mdrmux_sel(mdrmux_sel),
        .aluop(aluop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_timeout(mem_timeout)
    );

    logic [15:0] pc, ir, mar, mdr;
    logic [15:0] regs [8];
    logic [2:0]  cc;
    logic [7:0]  mem [65536];
    logic [1:0]  last_be;
    int          wcnt, latency, n_pulse, n_checks, n_fail;
    bit          never;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] w);
        mem[a]         = w[7:0];
        mem[a + 16'd1] = w[15:8];
    endtask

    function automatic logic [15:0] peek(input logic [15:0] a);
        return {mem[a + 16'd1], mem[a]};
    endfunction

    function automatic logic in_fetch1();
        return load_mar && load_pc && (marmux_sel == 2'd1) && !load_ir;
    endfunction

    task automatic drive_inputs();
        opcode        = lc3b_opcode'(ir[15:12]);
        jsr_mode      = ir[11];
        shf_mode      = ir[5:4];
        mar_lsb       = mar[0];
        branch_enable = |(ir[11:9] & cc);
    endtask

    // One clock of the datapath: called at the falling edge, returns at the next one.
    task automatic tick();
        logic [15:0] sr1, sr2, alu_b, alu, br_adder, rdata, pc_n, mar_n, mdr_n, rf_val, wdata;
        logic [2:0]  dest;
        logic        d_pc, d_ir, d_rf, d_mar, d_mdr, d_cc, d_wr, busy;
        logic [1:0]  be;
        mem_resp = (mem_read || mem_write) && !never && (wcnt == latency);
        #1;
        if (mem_timeout) n_pulse++;
        if (mem_write) last_be = mem_byte_enable;
        sr1 = regs[storemux_sel ? ir[11:9] : ir[8:6]];
        sr2 = ir[5] ? {{11{ir[4]}}, ir[4:0]} : regs[ir[2:0]];
        case (alumux_sel)
            2'd0:    alu_b = sr2;
            2'd1:    alu_b = {{9{ir[5]}}, ir[5:0], 1'b0};
            2'd2:    alu_b = {{10{ir[5]}}, ir[5:0]};
            default: alu_b = {12'h000, ir[3:0]};
        endcase
        case (aluop)
            alu_add:  alu = sr1 + alu_b;
            alu_and:  alu = sr1 & alu_b;
            alu_not:  alu = ~sr1;
            alu_pass: alu = sr1;
            alu_sll:  alu = sr1 << alu_b[3:0];
            alu_srl:  alu = sr1 >> alu_b[3:0];
            alu_sra:  alu = $signed(sr1) >>> alu_b[3:0];
            default:  alu = 'x;
        endcase
        br_adder = pc + (adjmux_sel ? {{4{ir[10]}}, ir[10:0], 1'b0} : {{6{ir[8]}}, ir[8:0], 1'b0});
        rdata = {mem[{mar[15:1], 1'b1}], mem[{mar[15:1], 1'b0}]};
        case (pcmux_sel)
            2'd0:    pc_n = pc + 16'd2;
            2'd1:    pc_n = br_adder;
            2'd2:    pc_n = sr1;
            default: pc_n = mdr;
        endcase
        case (marmux_sel)
            2'd0:    mar_n = alu;
            2'd1:    mar_n = pc;
            2'd2:    mar_n = mdr;
            default: mar_n = {7'h00, ir[7:0], 1'b0};
        endcase
        case (regfilemux_sel)
            3'd0:    rf_val = alu;
            3'd1:    rf_val = mdr;
            3'd2:    rf_val = mar[0] ? {8'h00, mdr[15:8]} : {8'h00, mdr[7:0]};
            3'd3:    rf_val = pc;
            3'd4:    rf_val = br_adder;
            default: rf_val = 'x;
        endcase
        mdr_n = mdrmux_sel ? rdata : alu;
        dest  = destmux_sel ? 3'd7 : ir[11:9];
        be    = mem_byte_enable;
        // The datapath replicates the low byte onto both lanes for byte stores.
        wdata = (be == 2'b11) ? mdr : {mdr[7:0], mdr[7:0]};
        {d_pc, d_ir, d_rf, d_mar, d_mdr, d_cc} = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc};
        d_wr = mem_write && mem_resp;
        busy = (mem_read || mem_write) && !mem_resp;
        @(posedge clk);
        #1;
        if (d_wr && be[0]) mem[{mar[15:1], 1'b0}] = wdata[7:0];
        if (d_wr && be[1]) mem[{mar[15:1], 1'b1}] = wdata[15:8];
        if (d_pc)  pc = pc_n;
        if (d_ir)  ir = mdr;
        if (d_rf)  regs[dest] = rf_val;
        if (d_mar) mar = mar_n;
        if (d_mdr) mdr = mdr_n;
        if (d_cc)  cc = rf_val[15] ? 3'b100 : (rf_val == 16'h0000) ? 3'b010 : 3'b001;
        wcnt = busy ? wcnt + 1 : 0;
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [15:0] addr, input logic [15:0] word,
                             input int exp_cycles);
        int cycles;
        poke(addr, word);
        pc = addr;
        drive_inputs();
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!in_fetch1() && cycles < 40);
        check({tag, " cycles"}, cycles, exp_cycles);
    endtask

    task automatic check_fetch1(input string tag);
        check({tag, " load_mar"}, load_mar, 1'b1);
        check({tag, " load_pc"}, load_pc, 1'b1);
        check({tag, " marmux"}, marmux_sel, 2'd1);
        check({tag, " pcmux"}, pcmux_sel, 2'd0);
        check({tag, " load_ir"}, load_ir, 1'b0);
        check({tag, " load_regfile"}, load_regfile, 1'b0);
        check({tag, " load_mdr"}, load_mdr, 1'b0);
        check({tag, " load_cc"}, load_cc, 1'b0);
        check({tag, " mem_read"}, mem_read, 1'b0);
        check({tag, " mem_write"}, mem_write, 1'b0);
        check({tag, " byte_enable"}, mem_byte_enable, 2'b11);
        check({tag, " mem_timeout"}, mem_timeout, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cycles;
        int p0;
        n_checks = 0; n_fail = 0; n_pulse = 0; wcnt = 0; latency = 0; never = 0;
        last_be = 2'b00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        pc = 16'h0000; ir = 16'h0000; mar = 16'h0000; mdr = 16'h0000; cc = 3'b010;
        reset = 1'b1; mem_resp = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_fetch1("reset");

        // ADD R1,R1,#3
        regs[1] = 16'h0004;
        run_instr("add", 16'h2000, 16'h1263, 5);
        check("add R1", regs[1], 16'h0007);
        check("add cc", cc, 3'b001);
        check("add pc", pc, 16'h2002);

        // NOT R1,R1
        regs[1] = 16'h00FF;
        run_instr("not", 16'h2010, 16'h927F, 5);
        check("not R1", regs[1], 16'hFF00);
        check("not cc", cc, 3'b100);

        // SHF R3,R4,#2 arithmetic, then mode 10 acting as logical right
        regs[4] = 16'h8000;
        run_instr("sra", 16'h2020, 16'hD732, 5);
        check("sra R3", regs[3], 16'hE000);
        run_instr("shf10", 16'h2022, 16'hD721, 5);
        check("shf10 R3", regs[3], 16'h4000);
        check("shf10 cc", cc, 3'b001);

        // STB R2,R5,#1 to odd byte 0x1001, then LDB from both lanes
        regs[5] = 16'h1000; regs[2] = 16'h00AB;
        mem[16'h1000] = 8'h5A;
        run_instr("stb", 16'h2030, 16'h3541, 7);
        check("stb byte_enable", last_be, 2'b10);
        check("stb mem 1001", mem[16'h1001], 8'hAB);
        check("stb mem 1000", mem[16'h1000], 8'h5A);
        run_instr("ldb even", 16'h2032, 16'h2D40, 7);
        check("ldb even R6", regs[6], 16'h005A);
        run_instr("ldb odd", 16'h2034, 16'h2D41, 7);
        check("ldb odd R6", regs[6], 16'h00AB);

        // LDI R0,R5,#0 through pointer at 0x3000
        regs[5] = 16'h3000;
        poke(16'h3000, 16'h4000);
        poke(16'h4000, 16'h1234);
        run_instr("ldi", 16'h2040, 16'hA140, 9);
        check("ldi R0", regs[0], 16'h1234);

        // STR R2,R5,#1 word store
        regs[2] = 16'hBEEF;
        run_instr("str", 16'h2050, 16'h7541, 7);
        check("str byte_enable", last_be, 2'b11);
        check("str mem", peek(16'h3002), 16'hBEEF);

        // JSRR R7, JSR, TRAP, BR taken/not taken, RET, LEA, RTI
        regs[7] = 16'h5000;
        run_instr("jsrr", 16'h2000, 16'h41C0, 5);
        check("jsrr pc", pc, 16'h5000);
        check("jsrr R7", regs[7], 16'h2002);
        run_instr("jsr", 16'h5000, 16'h4810, 5);
        check("jsr pc", pc, 16'h5022);
        check("jsr R7", regs[7], 16'h5002);
        poke(16'h004A, 16'h0600);
        run_instr("trap", 16'h5022, 16'hF025, 7);
        check("trap pc", pc, 16'h0600);
        check("trap R7", regs[7], 16'h5024);
        cc = 3'b001;
        run_instr("br taken", 16'h0600, 16'h0202, 6);
        check("br taken pc", pc, 16'h0606);
        run_instr("br not taken", 16'h0606, 16'h0802, 5);
        check("br not taken pc", pc, 16'h0608);
        run_instr("ret", 16'h0608, 16'hC1C0, 5);
        check("ret pc", pc, 16'h5024);
        run_instr("lea", 16'h0700, 16'hE604, 5);
        check("lea R3", regs[3], 16'h070A);
        regs[1] = 16'h1357;
        run_instr("rti", 16'h0710, 16'h8000, 4);
        check("rti pc", pc, 16'h0712);
        check("rti R1", regs[1], 16'h1357);

        // Watchdog: fetch never answered
        never = 1; p0 = n_pulse;
        run_instr("timeout", 16'h2100, 16'h1263, 6);
        check("timeout pulses", n_pulse - p0, 1);
        check("timeout pc", pc, 16'h2102);
        check("timeout low after", mem_timeout, 1'b0);
        never = 0;

        // Response landing on the limit cycle completes normally
        latency = 4; p0 = n_pulse;
        regs[1] = 16'hFFFD;
        run_instr("resp at limit", 16'h2200, 16'h1263, 9);
        check("resp at limit pulses", n_pulse - p0, 0);
        check("resp at limit R1", regs[1], 16'h0000);
        check("resp at limit cc", cc, 3'b010);
        latency = 0;

        // Reset during the str2 wait
        poke(16'h3002, 16'h6677);
        regs[5] = 16'h3000; regs[2] = 16'h1111;
        poke(16'h2300, 16'h7541);
        pc = 16'h2300;
        drive_inputs();
        cycles = 0;
        while (!mem_write && cycles < 20) begin
            tick();
            cycles++;
        end
        check("str2 reached", mem_write, 1'b1);
        never = 1;
        tick();
        reset = 1'b1;
        tick();
        check_fetch1("reset mid-store");
        reset = 1'b0; never = 0;
        check("reset mid-store mem", peek(16'h3002), 16'h6677);
        regs[1] = 16'h0010;
        run_instr("after reset add", 16'h2400, 16'h1263, 5);
        check("after reset R1", regs[1], 16'h0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_control_full.md
# lc3b_control_full

Multicycle Moore control FSM for the LC-3b datapath, covering the full non-privileged ISA. Beyond ADD/AND/NOT/BR/LDR/STR it adds SHF, LEA, JMP/RET, JSR/JSRR, TRAP, LDB/STB with byte lanes, LDI/STI indirection, and a parametrised memory-response watchdog. It sits between the IR/CC logic of the datapath and the unified memory port.

## Interface
Parameters:
- MEM_TIMEOUT, 0: maximum wait cycles for mem_resp; 0 disables the watchdog.
- TIMEOUT_W, $clog2(MEM_TIMEOUT+2): width of the wait counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  lc3b_opcode  IR[15:12].
- branch_enable  in  1  NZP match from datapath.
- jsr_mode  in  1  IR[11]; 1 = JSR, 0 = JSRR.
- shf_mode  in  2  IR[5:4].
- mar_lsb  in  1  MAR[0] byte select.
- mem_resp  in  1  memory done.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each.
- pcmux_sel  out  2  0 PC+2, 1 br_adder, 2 SR1, 3 MDR.
- adjmux_sel  out  1  br_adder offset: 0 off9, 1 off11.
- marmux_sel  out  2  0 alu_out, 1 PC, 2 MDR, 3 zext(trapvect8)<<1.
- regfilemux_sel  out  3  0 alu_out, 1 MDR word, 2 MDR byte zext (lane by mar_lsb), 3 PC, 4 br_adder.
- destmux_sel  out  1  0 IR[11:9], 1 R7.
- alumux_sel  out  2  0 SR2/imm5, 1 off6<<1, 2 sext off6, 3 imm4.
- storemux_sel, mdrmux_sel  out  1 each  SR1 src 0 IR[8:6]/1 IR[11:9]; MDR 0 alu_out/1 mem_rdata.
- aluop  out  lc3b_aluop.
- mem_read, mem_write  out  1 each.
- mem_byte_enable  out  2  lane mask.
- mem_timeout  out  1  one-cycle abort pulse.

## Operation
- Outputs are a function of state plus listed inputs. Defaults: all loads/mem 0, selects 0, aluop add, byte_enable 2'b11.
- fetch1: MAR<=PC, PC<=PC+2. fetch2: read into MDR, hold until resp. fetch3: load_ir. decode: dispatch.
- s_add/s_and: alumux 0, load_regfile, load_cc. s_not: aluop not. s_shf: alumux 3, aluop sll (00) / srl (01) / sra (11); shf_mode 10 is treated as srl.
- s_lea: regfilemux 4, adj 0, load_regfile, load_cc.
- s_br -> s_br_taken if branch_enable, else fetch1. s_br_taken: pcmux 1, adj 0.
- s_jmp: pcmux 2. s_jsr: R7<=PC (destmux 1, regfilemux 3) and PC <= jsr_mode ? br_adder(adj 1) : SR1, both in the same cycle. SR1 reads the pre-edge value, so JSRR R7 is correct.
- LDR/STR/LDI/STI: calc_addr (alumux 1). LDB/STB: calc_addr_b (alumux 2).
- LDI/STI: s_ind1 reads the pointer into MDR, waiting for resp. s_ind2 does MAR<=MDR (marmux 2). Then continue to ldr1/str1.
- ldr1 reads into MDR (wait). ldr2: regfilemux 1, load_cc.
- ldb1 reads into MDR (wait). ldb2: regfilemux 2, load_cc.
- str1/stb1: storemux 1, aluop pass, MDR<=alu_out. str2 writes with byte_enable 11, waiting for resp.
- stb2 writes with byte_enable = mar_lsb ? 2'b10 : 2'b01.
- TRAP: trap1 does R7<=PC and MAR<=vector. trap2 reads into MDR (wait). trap3: PC<=MDR.
- RTI and unused opcodes: decode goes straight to fetch1, with no side effects.
- Watchdog:
  - The counter clears on entry to any memory-wait state and increments each cycle that resp is low.
  - If MEM_TIMEOUT>0 and the count equals MEM_TIMEOUT with resp still low, the next state is fetch1 and mem_timeout is 1 that cycle.
  - The instruction is abandoned, and the PC stays advanced.
  - resp arriving in the same cycle as the timeout wins: normal progression, no pulse.

## Timing
- Reset: state<=fetch1 and counter<=0. Post-reset outputs are the fetch1 values: load_mar=1, load_pc=1, marmux 1, pcmux 0; all others 0; byte_enable 11; mem_timeout 0.
- Reset asserted mid-access wins immediately. mem_read/mem_write drop the cycle after the edge.
- With single-cycle mem_resp:
  - ADD/AND/NOT/SHF/LEA/JMP/JSR: 5 cycles.
  - BR: 5 cycles not taken, 6 taken.
  - LDR/STR/LDB/STB: 7 cycles.
  - LDI/STI: 9 cycles.
  - TRAP: 7 cycles.
- Each additional wait cycle adds 1 cycle per access.
- mem_read/mem_write stay high continuously until the cycle mem_resp is sampled high.

## Structure
- Extend the lc3b_types package:
  - add alu_sll, alu_srl, alu_sra to lc3b_aluop;
  - add enums lc3b_pcmux_sel, lc3b_marmux_sel, lc3b_regfilemux_sel, lc3b_alumux_sel with the encodings above.
- One sub-module, mem_wait_timer: the counter and compare, parametrised by MEM_TIMEOUT, with inputs clear and resp and output expired.

## Test plan
- Reset, then ADD R1,R1,#3 with R1=4 and 1-cycle memory: R1=7, CC=P, back in fetch1 at cycle 5.
- STB with MAR=0x1001, R2=0x00AB: stb2 drives byte_enable 2'b10 and memory byte at 0x1001 becomes 0xAB. LDB from 0x1000 zero-extends.
- LDI with pointer at 0x3000 = 0x4000 and M[0x4000]=0x1234: DR=0x1234, 9 cycles.
- JSRR R7 with R7=0x5000 at PC 0x2000: PC=0x5000, R7=0x2002. TRAP x25 with M[0x4A]=0x0600: PC=0x0600.
- MEM_TIMEOUT=4 with memory never responding in fetch2: mem_timeout pulses exactly once, state returns to fetch1, PC has advanced by 2. resp coinciding with the limit gives no pulse.
- Assert reset during the str2 wait: mem_write is 0 the next cycle and the outputs match the fetch1 values.
